// File: rtl/uart_word_tx_if.sv
// uart_word_tx_if: word-transmit request and UART line status bundle
interface uart_word_tx_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BN_W       = $clog2(DATA_WIDTH / 8) + 1
);
    logic [DATA_WIDTH-1:0] data;
    logic                  send_en;
    logic [BN_W-1:0]       Byte_Num;
    logic [2:0]            Baud_Set;
    logic                  uart_tx;
    logic                  Tx_Done;
    logic                  Byte_Done;
    logic                  uart_state;
    modport master (
        output data, send_en, Byte_Num, Baud_Set,
        input  uart_tx, Tx_Done, Byte_Done, uart_state
    );
    modport slave (
        input  data, send_en, Byte_Num, Baud_Set,
        output uart_tx, Tx_Done, Byte_Done, uart_state
    );
endinterface

// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises a multi-byte word as back-to-back UART frames
module uart_word_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int GAP_BITS   = 0,
    parameter int CLK_HZ     = 50000000
) (
    input  logic          Clk,
    input  logic          Rst_n,
    uart_word_tx_if.slave s
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int BN_W = $clog2(NB) + 1;
    localparam int CW   = $clog2(CLK_HZ / 9600 + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} state_t;

    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_word;
    logic [BN_W-1:0]       r_nbytes, r_byte_cnt, w_nbytes;
    logic [CW-1:0]         r_div, r_bit_cnt, w_div;
    logic [3:0]            r_per_cnt, w_per_len;
    logic [7:0]            w_byte;
    logic                  w_tick, w_per_end, w_last, w_parity, w_byte_done, w_tx;

    assign w_div = s.Baud_Set == 3'd0 ? CW'(CLK_HZ / 9600)  :
                   s.Baud_Set == 3'd1 ? CW'(CLK_HZ / 19200) :
                   s.Baud_Set == 3'd2 ? CW'(CLK_HZ / 38400) :
                   s.Baud_Set == 3'd3 ? CW'(CLK_HZ / 57600) : CW'(CLK_HZ / 115200);
    assign w_nbytes = (s.Byte_Num == '0 || s.Byte_Num > BN_W'(NB)) ? BN_W'(NB) : s.Byte_Num;
    // The word shifts toward the first-sent end after each byte, so the current byte is always there
    assign w_byte    = MSB_FIRST != 0 ? r_word[DATA_WIDTH-1 -: 8] : r_word[7:0];
    assign w_parity  = (PARITY == 1) ^ (^w_byte);
    assign w_tick    = r_bit_cnt == r_div - 1'b1;
    assign w_per_len = r_state == DATA ? 4'd8 : r_state == STOP ? 4'(STOP_BITS) :
                       r_state == GAP ? 4'(GAP_BITS) : 4'd1;
    assign w_per_end = w_tick && r_per_cnt == w_per_len - 4'd1;
    assign w_last    = r_byte_cnt == r_nbytes - 1'b1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_tx        = 1'b1;
        w_byte_done = 1'b0;
        case (r_state)
            IDLE:  if (s.send_en) w_next = START;
            START: begin
                w_tx = 1'b0;
                if (w_per_end) w_next = DATA;
            end
            DATA: begin
                w_tx = w_byte[r_per_cnt[2:0]];
                if (w_per_end) w_next = PARITY != 0 ? PAR : STOP;
            end
            PAR: begin
                w_tx = w_parity;
                if (w_per_end) w_next = STOP;
            end
            STOP: if (w_per_end) begin
                w_byte_done = 1'b1;
                w_next      = w_last ? IDLE : GAP_BITS > 0 ? GAP : START;
            end
            GAP:     if (w_per_end) w_next = START;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_word     <= '0;
            r_nbytes   <= '0;
            r_byte_cnt <= '0;
            r_div      <= '0;
            r_bit_cnt  <= '0;
            r_per_cnt  <= '0;
        end else if (r_state == IDLE) begin
            r_bit_cnt  <= '0;
            r_per_cnt  <= '0;
            r_byte_cnt <= '0;
            if (s.send_en) begin
                r_word   <= s.data;
                r_nbytes <= w_nbytes;
                r_div    <= w_div;
            end
        end else begin
            r_bit_cnt <= w_tick ? '0 : r_bit_cnt + 1'b1;
            if (w_tick) r_per_cnt <= w_per_end ? '0 : r_per_cnt + 1'b1;
            if (w_byte_done) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
                r_word     <= MSB_FIRST != 0 ? r_word << 8 : r_word >> 8;
            end
        end
    end

    assign s.uart_tx    = w_tx;
    assign s.Byte_Done  = w_byte_done;
    assign s.Tx_Done    = w_byte_done && w_last;
    assign s.uart_state = r_state != IDLE;
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: scoreboard bench decoding the serial line of three configurations
module tb_uart_word_tx;
    logic        Clk = 1'b0, Rst_n = 1'b0;
    logic [31:0] data_a[3];
    logic [2:0]  bn_a[3], baud_a[3];
    logic        en_a[3];
    logic        tx_w[3], td_w[3], bd_w[3], st_w[3];
    int          sel = 0, div_cur = 10, cyc = 0, acc = 0, rst_cnt = 0;
    int          bd_cnt = 0, td_cnt = 0, checks = 0, errors = 0;
    logic [11:0] exp_q[$];
    logic        line;

    always #5 Clk = ~Clk;

    // 0: MSB first, no parity; 1: LSB first, even parity, 2 stop, 3 gap; 2: LSB first, plain
    for (genvar g = 0; g < 3; g++) begin : gen
        uart_word_tx_if #(.DATA_WIDTH(32)) u_if ();
        assign u_if.data     = data_a[g];
        assign u_if.send_en  = en_a[g];
        assign u_if.Byte_Num = bn_a[g];
        assign u_if.Baud_Set = baud_a[g];
        assign tx_w[g] = u_if.uart_tx;
        assign td_w[g] = u_if.Tx_Done;
        assign bd_w[g] = u_if.Byte_Done;
        assign st_w[g] = u_if.uart_state;
        uart_word_tx #(
            .DATA_WIDTH(32), .MSB_FIRST(g == 0 ? 1 : 0), .PARITY(g == 1 ? 2 : 0),
            .STOP_BITS(g == 1 ? 2 : 1), .GAP_BITS(g == 1 ? 3 : 0), .CLK_HZ(1152000)
        ) u_dut (.Clk(Clk), .Rst_n(Rst_n), .s(u_if.slave));
    end

    assign line = tx_w[sel];

    always @(posedge Clk) cyc <= cyc + 1;
    always @(negedge Rst_n) rst_cnt++;
    always @(negedge Clk) begin
        if (bd_w[sel]) bd_cnt++;
        if (td_w[sel]) td_cnt++;
    end

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic void push(input int s, input logic p, input logic [7:0] b);
        exp_q.push_back({2'(s), 1'b1, p, b});
    endfunction

    task automatic start(input int s, input logic [31:0] d, input logic [2:0] bn, input logic [2:0] baud);
        sel = s;
        data_a[s] = d;
        bn_a[s] = bn;
        baud_a[s] = baud;
        en_a[s] = 1'b1;
        @(negedge Clk);
        en_a[s] = 1'b0;
        acc = cyc;
        chk("start_busy", 32'(st_w[s]), 32'd1);
        chk("start_bit", 32'(tx_w[s]), 32'd0);
    endtask

    task automatic wait_done(input string name, input int exp);
        int n = 0;
        while (!td_w[sel] && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        chk(name, 32'(cyc - acc + 1), 32'(exp));
    endtask

    // Line decoder: samples mid-bit and scores each complete, un-aborted frame
    initial begin
        logic [7:0]  b;
        logic        p, stp;
        int          r0;
        logic [11:0] e;
        forever begin
            @(negedge line);
            r0 = rst_cnt;
            repeat (div_cur / 2) @(negedge Clk);
            stp = ~line;
            for (int i = 0; i < 8; i++) begin
                repeat (div_cur) @(negedge Clk);
                b[i] = line;
            end
            p = 1'b0;
            if (sel == 1) begin
                repeat (div_cur) @(negedge Clk);
                p = line;
            end
            repeat (div_cur) @(negedge Clk);
            stp &= line;
            if (sel == 1) begin
                repeat (div_cur) @(negedge Clk);
                stp &= line;
            end
            if (rst_cnt == r0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_frame: got byte %0h on config %0d, expected none", b, sel);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame", {20'd0, 2'(sel), stp, p, b}, {20'd0, e});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            data_a[i] = '0;
            bn_a[i]   = '0;
            baud_a[i] = 3'd4;
            en_a[i]   = 1'b0;
        end
        repeat (3) @(negedge Clk);
        for (int i = 0; i < 3; i++) chk("reset_out", 32'({tx_w[i], td_w[i], bd_w[i], st_w[i]}), 32'h8);
        Rst_n = 1'b1;
        push(0, 0, 8'h12); push(0, 0, 8'h34); push(0, 0, 8'h56); push(0, 0, 8'h78);
        start(0, 32'h12345678, 3'd0, 3'd4);
        wait_done("word4_done", 400);
        @(negedge Clk);
        chk("word4_byte_done", 32'(bd_cnt), 32'd4);
        push(0, 0, 8'hA1);
        start(0, 32'hA1B2C3D4, 3'd1, 3'd4);
        repeat (4) @(negedge Clk);
        data_a[0] = 32'hFFFFFFFF;
        en_a[0] = 1'b1;
        @(negedge Clk);
        en_a[0] = 1'b0;
        repeat (44) @(negedge Clk);
        en_a[0] = 1'b1;
        @(negedge Clk);
        en_a[0] = 1'b0;
        wait_done("busy_ignore_done", 100);
        en_a[0] = 1'b1;
        data_a[0] = 32'hEE000000;
        bn_a[0] = 3'd1;
        @(negedge Clk);
        chk("done_cycle_ignored", 32'(st_w[0]), 32'd0);
        push(0, 0, 8'h3C);
        start(0, 32'h3C000000, 3'd1, 3'd4);
        wait_done("next_cycle_done", 100);
        @(negedge Clk);
        div_cur = 120;
        push(0, 0, 8'h5A);
        start(0, 32'h5A000000, 3'd1, 3'd0);
        repeat (300) @(negedge Clk);
        baud_a[0] = 3'd4;
        wait_done("baud9600_done", 1200);
        @(negedge Clk);
        div_cur = 10;
        push(0, 0, 8'h11);
        start(0, 32'h11223344, 3'd0, 3'd4);
        repeat (149) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        chk("abort_tx", 32'(tx_w[0]), 32'd1);
        chk("abort_state", 32'(st_w[0]), 32'd0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (200) @(negedge Clk);
        push(0, 0, 8'hC3);
        start(0, 32'hC3000000, 3'd1, 3'd4);
        wait_done("after_reset_done", 100);
        @(negedge Clk);
        push(2, 0, 8'hDD); push(2, 0, 8'hCC);
        start(2, 32'hAABBCCDD, 3'd2, 3'd4);
        wait_done("lsb2_done", 200);
        @(negedge Clk);
        push(1, 1, 8'h07);
        start(1, 32'h00000007, 3'd1, 3'd4);
        wait_done("parity_frame_done", 120);
        @(negedge Clk);
        push(1, 0, 8'h00); push(1, 0, 8'h03);
        start(1, 32'h00000300, 3'd2, 3'd4);
        wait_done("gap_word_done", 270);
        repeat (20) @(negedge Clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("byte_done_total", 32'(bd_cnt), 32'd14);
        chk("tx_done_total", 32'(td_cnt), 32'd8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the data word; SHALL be a multiple of 8 in the range 8..256.
REQ-002 Parameter MSB_FIRST, default 1: 1 = most-significant byte sent first; 0 = least-significant byte sent first; bits within a byte are always sent LSB first.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1: number of stop bits, 1 or 2.
REQ-005 Parameter GAP_BITS, default 0: idle-high bit periods inserted between bytes of one word, 0..15.
REQ-006 Parameter CLK_HZ, default 50000000: Clk frequency used to derive bit-period divisors.
REQ-007 Clk  input  1  clock; all logic on rising edge.
REQ-008 Rst_n  input  1  reset, asynchronous, active-low.
REQ-009 data  input  DATA_WIDTH  word to transmit; sampled only on an accepted send_en.
REQ-010 send_en  input  1  start request; accepted only when uart_state=0.
REQ-011 Byte_Num  input  ceil(log2(DATA_WIDTH/8))+1  bytes to send; sampled with data.
REQ-012 Baud_Set  input  3  0:9600, 1:19200, 2:38400, 3:57600, 4..7:115200; sampled with data.
REQ-013 uart_tx  output  1  serial line, idle high.
REQ-014 Tx_Done  output  1  one-cycle pulse when the whole word has finished.
REQ-015 Byte_Done  output  1  one-cycle pulse at the end of each byte's last stop bit.
REQ-016 uart_state  output  1  1 while busy, from the cycle after acceptance until Tx_Done.

Function
REQ-017 Bit period SHALL be DIV = floor(CLK_HZ/baud) Clk cycles, with DIV held constant for the whole word.
REQ-018 On a send_en accepted in cycle N, data, Byte_Num and Baud_Set SHALL be latched, uart_state SHALL be 1 from N+1, and the start bit (uart_tx=0) SHALL begin at N+1.
REQ-019 send_en while uart_state=1 SHALL be ignored: no latching and no effect on the current word.
REQ-020 An effective byte count of Byte_Num=0 or Byte_Num>DATA_WIDTH/8 SHALL be DATA_WIDTH/8.
REQ-021 The bytes sent SHALL be the Byte_Num bytes adjacent to the first-sent end: the top bytes when MSB_FIRST=1, the bottom bytes when MSB_FIRST=0.
REQ-022 FSM states SHALL be IDLE, START, DATA, PAR, STOP, GAP, each state lasting whole bit periods.
REQ-023 FSM transitions:
- IDLE->START on accept.
- START->DATA after 1 period.
- DATA->PAR (PARITY!=0) or DATA->STOP after 8 periods.
- PAR->STOP after 1 period.
- STOP, after STOP_BITS periods: ->IDLE if last byte; else ->GAP if GAP_BITS>0; else ->START.
- GAP->START after GAP_BITS periods.
REQ-024 Parity bit SHALL be XOR of the 8 data bits for even parity, and its inverse for odd parity.
REQ-025 uart_tx SHALL be 1 in IDLE, STOP and GAP.
REQ-026 Byte_Done SHALL pulse in the last cycle of each byte's final stop period.
REQ-027 Tx_Done SHALL pulse in that same cycle for the last byte; uart_state SHALL return to 0 in the following cycle.
REQ-028 A send_en asserted in the same cycle as Tx_Done SHALL be ignored; the earliest acceptance is the next cycle, with no extra idle period required.
REQ-029 The internal bit counter SHALL count 0..DIV-1 and wrap without overflow for every DIV up to CLK_HZ/9600.
REQ-030 The byte counter SHALL be wide enough for DATA_WIDTH/8, with no wrap-around within a word.

Reset
REQ-031 While Rst_n=0 the block SHALL hold uart_tx=1, Tx_Done=0, Byte_Done=0, uart_state=0, FSM=IDLE, and all counters at 0.
REQ-032 Reset asserted mid-word SHALL abort the word immediately, with uart_tx high at once.
REQ-033 After Rst_n rises, the first send_en SHALL be accepted on the first clock edge.

Verification (CLK_HZ=1152000, so DIV=10 at 115200)
REQ-034 DATA_WIDTH=32, MSB_FIRST=1, PARITY=0, data=0x12345678, Byte_Num=0, Baud_Set=4 -> bytes 0x12,0x34,0x56,0x78 on the line; 4 Byte_Done pulses; Tx_Done exactly 400 cycles after acceptance.
REQ-035 MSB_FIRST=0, Byte_Num=2, data=0xAABBCCDD -> bytes 0xDD then 0xCC; Tx_Done at 200 cycles.
REQ-036 PARITY=2, STOP_BITS=2, GAP_BITS=3, Byte_Num=1, data byte 0x07 -> parity bit 1; frame length 12 periods; no gap after the last byte.
REQ-037 send_en pulsed at cycles 5 and 50 of a busy word -> only one word is sent; the second request is ignored; send_en in the Tx_Done cycle is also ignored.
REQ-038 Rst_n pulled low during the DATA state of byte 2 -> uart_tx=1 and uart_state=0 immediately; a new word starts cleanly after release.
REQ-039 Baud_Set=0 with CLK_HZ=1152000 -> DIV=120; Baud_Set changed mid-word has no effect on the current word.
